// File: rtl/dll_pkg.sv
// Shared types and helpers for the data-link-layer replay buffer.
package dll_pkg;

    localparam int unsigned SEQ_W = 12;
    localparam logic [SEQ_W-1:0] SEQ_HALF = SEQ_W'(2048);

    typedef enum logic [1:0] {
        StIdle,
        StPurge,
        StReplay
    } state_e;

    // Entry e is covered by ACK/NAK sequence s when it lies in the half-window behind s.
    function automatic logic seq_covered(input logic [SEQ_W-1:0] s, input logic [SEQ_W-1:0] e);
        logic [SEQ_W-1:0] diff;
        diff = s - e;
        return diff < SEQ_HALF;
    endfunction

endpackage

// File: rtl/replay_mem.sv
// Replay storage: synchronous write, two asynchronous reads (send entry, purge sequence).
module replay_mem #(
    parameter int unsigned Width = 172,
    parameter int unsigned SeqW  = 12,
    parameter int unsigned Depth = 4,
    localparam int unsigned AW   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AW-1:0]    send_addr_i,
    output logic [Width-1:0] send_data_o,
    input  logic [AW-1:0]    purge_addr_i,
    output logic [SeqW-1:0]  purge_seq_o
);

    logic [Width-1:0] mem_q [Depth];

    // Contents are not reset; only the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign send_data_o = mem_q[send_addr_i];
    // Sequence number sits in the top bits of each entry.
    assign purge_seq_o = mem_q[purge_addr_i][Width-1 -: SeqW];

endmodule

// File: rtl/replay_buffer.sv
// Retransmit store: holds framed TLPs until ACKed, replays all held entries on NAK.
module replay_buffer
    import dll_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = 128,
    parameter int unsigned DEPTH       = 4,
    localparam int unsigned PktW       = PACKET_SIZE + 32,
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned PW         = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PktW-1:0]  in_pkt,
    input  logic [SEQ_W-1:0] in_seq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PktW-1:0]  out_pkt,
    output logic [SEQ_W-1:0] out_seq,
    input  logic             ack_valid,
    input  logic             ack_nak,
    input  logic [SEQ_W-1:0] ack_seq,
    output logic             ack_ready,
    output logic             replay_active,
    output logic             replay_rollover,
    output logic             ack_err,
    output logic [PW-1:0]    count
);

    localparam logic [PW-1:0] DepthP = PW'(DEPTH);

    state_e           state_q, state_d;
    logic [PW-1:0]    rd_q, rd_d, send_q, send_d, wr_q, wr_d;
    logic [SEQ_W-1:0] s_q, s_d;
    logic             nak_q, nak_d;
    logic             freed_q, freed_d;
    logic [1:0]       num_q, num_d;
    logic             roll_q, roll_d;
    logic             err_q, err_d;

    logic             wr_fire, send_fire, rd_covered;
    logic [SEQ_W-1:0] rd_seq;
    logic [PktW+SEQ_W-1:0] send_entry;

    replay_mem #(
        .Width (PktW + SEQ_W),
        .SeqW  (SEQ_W),
        .Depth (DEPTH)
    ) u_mem (
        .clk_i        (clk),
        .we_i         (wr_fire),
        .waddr_i      (wr_q[AW-1:0]),
        .wdata_i      ({in_seq, in_pkt}),
        .send_addr_i  (send_q[AW-1:0]),
        .send_data_o  (send_entry),
        .purge_addr_i (rd_q[AW-1:0]),
        .purge_seq_o  (rd_seq)
    );

    assign count           = wr_q - rd_q;
    assign in_ready        = (count < DepthP) && (state_q != StReplay);
    assign out_valid       = (send_q != wr_q);
    assign out_pkt         = send_entry[PktW-1:0];
    assign out_seq         = send_entry[PktW +: SEQ_W];
    assign ack_ready       = (state_q == StIdle);
    assign replay_active   = (state_q == StReplay);
    assign replay_rollover = roll_q;
    assign ack_err         = err_q;

    assign wr_fire    = in_valid && in_ready;
    assign send_fire  = out_valid && out_ready;
    assign rd_covered = seq_covered(s_q, rd_seq);

    // Next-state: pointer movement, purge walk, replay control and pulse generation.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        send_d  = send_fire ? send_q + PW'(1) : send_q;
        wr_d    = wr_fire ? wr_q + PW'(1) : wr_q;
        s_d     = s_q;
        nak_d   = nak_q;
        freed_d = freed_q;
        num_d   = num_q;
        roll_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ack_valid) begin
                    s_d     = ack_seq;
                    nak_d   = ack_nak;
                    freed_d = 1'b0;
                    state_d = StPurge;
                end
            end
            StPurge: begin
                if ((rd_q != send_q) && rd_covered) begin
                    rd_d    = rd_q + PW'(1);
                    freed_d = 1'b1;
                    num_d   = 2'd0;
                end else begin
                    // Coverage reaching past the last sent entry is a protocol error.
                    if ((rd_q == send_q) && rd_covered && (rd_q != wr_q)) begin
                        err_d = 1'b1;
                    end
                    if (nak_q) begin
                        send_d  = rd_q;
                        state_d = StReplay;
                        if (!freed_q) begin
                            num_d  = num_q + 2'd1;
                            roll_d = (num_q == 2'd3);
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StReplay: begin
                if (!out_valid || (send_fire && (send_q + PW'(1) == wr_q))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rd_q    <= '0;
            send_q  <= '0;
            wr_q    <= '0;
            s_q     <= '0;
            nak_q   <= 1'b0;
            freed_q <= 1'b0;
            num_q   <= 2'd0;
            roll_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            send_q  <= send_d;
            wr_q    <= wr_d;
            s_q     <= s_d;
            nak_q   <= nak_d;
            freed_q <= freed_d;
            num_q   <= num_d;
            roll_q  <= roll_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_replay_buffer.sv
// Directed self-checking bench for replay_buffer.
module tb_replay_buffer;

    localparam int unsigned PACKET_SIZE = 128;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned PktW        = PACKET_SIZE + 32;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [PktW-1:0] in_pkt;
    logic [11:0]     in_seq;
    logic            out_valid;
    logic            out_ready;
    logic [PktW-1:0] out_pkt;
    logic [11:0]     out_seq;
    logic            ack_valid;
    logic            ack_nak;
    logic [11:0]     ack_seq;
    logic            ack_ready;
    logic            replay_active;
    logic            replay_rollover;
    logic            ack_err;
    logic [2:0]      count;

    int n_checks = 0;
    int n_errors = 0;

    replay_buffer #(
        .PACKET_SIZE (PACKET_SIZE),
        .DEPTH       (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pkt          (in_pkt),
        .in_seq          (in_seq),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pkt         (out_pkt),
        .out_seq         (out_seq),
        .ack_valid       (ack_valid),
        .ack_nak         (ack_nak),
        .ack_seq         (ack_seq),
        .ack_ready       (ack_ready),
        .replay_active   (replay_active),
        .replay_rollover (replay_rollover),
        .ack_err         (ack_err),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PktW-1:0] make_pkt(input logic [11:0] s);
        return {5{20'hC0FFE, s}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // NAK that covers nothing, followed by a full replay of `held` entries starting at `base`.
    task automatic stale_nak(input int base, input int held, input bit exp_roll);
        logic [PktW-1:0] exp_pkt;
        ack_valid = 1'b1;
        ack_nak   = 1'b1;
        ack_seq   = 12'hFFF;
        out_ready = 1'b1;
        check("snak_accept", 32'(ack_ready), 1);
        step();
        ack_valid = 1'b0;
        check("snak_purge_ack_ready", 32'(ack_ready), 0);
        check("snak_purge_count", 32'(count), 32'(held));
        step();
        for (int j = 0; j < held; j++) begin
            exp_pkt = make_pkt(12'(base + j));
            check("snak_rep_active", 32'(replay_active), 1);
            check("snak_rep_seq", 32'(out_seq), 32'(base + j));
            check("snak_rep_pkt_lo", out_pkt[31:0], exp_pkt[31:0]);
            check("snak_rollover", 32'(replay_rollover), 32'(exp_roll && (j == 0)));
            step();
        end
        check("snak_done", 32'(replay_active), 0);
        check("snak_roll_clear", 32'(replay_rollover), 0);
    endtask

    initial begin
        logic [PktW-1:0] exp_pkt;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pkt    = '0;
        in_seq    = '0;
        out_ready = 1'b0;
        ack_valid = 1'b0;
        ack_nak   = 1'b0;
        ack_seq   = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_ack_ready", 32'(ack_ready), 1);
        check("rst_replay_active", 32'(replay_active), 0);

        // Write seq 0..3 while transmitting each one the cycle after its write.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_seq   = 12'(i);
            in_pkt   = make_pkt(12'(i));
            check("fill_in_ready", 32'(in_ready), 1);
            if (i > 0) begin
                check("fill_out_valid", 32'(out_valid), 1);
                check("fill_out_seq", 32'(out_seq), 32'(i - 1));
            end else begin
                check("fill_out_valid0", 32'(out_valid), 0);
            end
            step();
        end
        in_valid = 1'b0;
        check("fill_last_seq", 32'(out_seq), 3);
        step();
        out_ready = 1'b0;
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_out_valid", 32'(out_valid), 0);

        // ACK seq 1 with four held: two purge cycles plus the terminating one.
        ack_valid = 1'b1;
        ack_nak   = 1'b0;
        ack_seq   = 12'd1;
        step();
        ack_valid = 1'b0;
        check("ack_p1_ready", 32'(ack_ready), 0);
        check("ack_p1_count", 32'(count), 4);
        step();
        check("ack_p2_ready", 32'(ack_ready), 0);
        check("ack_p2_count", 32'(count), 3);
        check("ack_p2_in_ready", 32'(in_ready), 1);
        step();
        check("ack_p3_ready", 32'(ack_ready), 0);
        check("ack_p3_count", 32'(count), 2);
        step();
        check("ack_idle_ready", 32'(ack_ready), 1);
        check("ack_idle_count", 32'(count), 2);
        check("ack_idle_err", 32'(ack_err), 0);

        // Fresh buffer: seq 0..3 sent, then NAK seq 1 purges two and replays 2,3.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            in_seq   = 12'(i);
            in_pkt   = make_pkt(12'(i));
            step();
        end
        in_valid  = 1'b0;
        ack_valid = 1'b1;
        ack_nak   = 1'b1;
        ack_seq   = 12'd1;
        step();
        ack_valid = 1'b0;
        step();
        step();
        check("nak_purge_end_count", 32'(count), 2);
        step();
        in_valid = 1'b1;
        in_seq   = 12'd9;
        in_pkt   = make_pkt(12'd9);
        exp_pkt  = make_pkt(12'd2);
        check("nak_rep0_active", 32'(replay_active), 1);
        check("nak_rep0_in_ready", 32'(in_ready), 0);
        check("nak_rep0_seq", 32'(out_seq), 2);
        check("nak_rep0_pkt_lo", out_pkt[31:0], exp_pkt[31:0]);
        check("nak_rep0_pkt_hi", out_pkt[159:128], exp_pkt[159:128]);
        check("nak_rep0_roll", 32'(replay_rollover), 0);
        step();
        exp_pkt = make_pkt(12'd3);
        check("nak_rep1_active", 32'(replay_active), 1);
        check("nak_rep1_in_ready", 32'(in_ready), 0);
        check("nak_rep1_seq", 32'(out_seq), 3);
        check("nak_rep1_pkt_hi", out_pkt[159:128], exp_pkt[159:128]);
        step();
        in_valid = 1'b0;
        check("nak_done_active", 32'(replay_active), 0);
        check("nak_done_out_valid", 32'(out_valid), 0);
        check("nak_done_count", 32'(count), 2);
        check("nak_done_in_ready", 32'(in_ready), 1);

        // Four stale NAKs wrap the replay counter on the fourth.
        stale_nak(2, 2, 1'b0);
        stale_nak(2, 2, 1'b0);
        stale_nak(2, 2, 1'b0);
        stale_nak(2, 2, 1'b1);
        // Counter now at 1; a covering ACK must clear it.
        stale_nak(2, 2, 1'b0);
        ack_valid = 1'b1;
        ack_nak   = 1'b0;
        ack_seq   = 12'd2;
        step();
        ack_valid = 1'b0;
        step();
        step();
        check("clr_count", 32'(count), 1);
        stale_nak(3, 1, 1'b0);
        stale_nak(3, 1, 1'b0);
        stale_nak(3, 1, 1'b0);
        stale_nak(3, 1, 1'b1);

        // ACK covering an unsent entry: purge 0,1 then flag the error.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_seq = 12'(i);
            in_pkt = make_pkt(12'(i));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("err_pre_seq", 32'(out_seq), 2);
        check("err_pre_count", 32'(count), 3);
        ack_valid = 1'b1;
        ack_nak   = 1'b0;
        ack_seq   = 12'd2;
        step();
        ack_valid = 1'b0;
        check("err_p1", 32'(ack_err), 0);
        step();
        step();
        check("err_p3", 32'(ack_err), 0);
        step();
        check("err_pulse", 32'(ack_err), 1);
        check("err_out_seq", 32'(out_seq), 2);
        check("err_out_valid", 32'(out_valid), 1);
        check("err_count", 32'(count), 1);
        step();
        check("err_clear", 32'(ack_err), 0);

        // Reset mid-replay.
        ack_valid = 1'b1;
        ack_nak   = 1'b1;
        ack_seq   = 12'hFFF;
        step();
        ack_valid = 1'b0;
        step();
        check("mid_rep_active", 32'(replay_active), 1);
        reset = 1'b1;
        step();
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_count", 32'(count), 0);
        check("mrst_in_ready", 32'(in_ready), 1);
        check("mrst_active", 32'(replay_active), 0);
        reset = 1'b0;

        // NAK on an empty buffer: one purge cycle, one replay cycle.
        ack_valid = 1'b1;
        ack_nak   = 1'b1;
        ack_seq   = 12'd0;
        step();
        ack_valid = 1'b0;
        check("empty_purge_ready", 32'(ack_ready), 0);
        step();
        check("empty_rep_active", 32'(replay_active), 1);
        check("empty_rep_valid", 32'(out_valid), 0);
        step();
        check("empty_done_active", 32'(replay_active), 0);
        check("empty_done_ready", 32'(ack_ready), 1);
        check("empty_done_err", 32'(ack_err), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/replay_buffer.md
# replay_buffer

Data-link-layer retransmit store sitting directly downstream of the LCRC generator. It accepts framed TLPs (payload plus 32-bit LCRC) tagged with a 12-bit sequence number and forwards them to the physical-layer transmitter. Each packet is held until the link partner ACKs it. On a NAK, every packet still held is retransmitted in order, oldest first.

## Interface
- PACKET_SIZE, 128, TLP payload bits; stored entry is PACKET_SIZE+32 bits (TLP plus LCRC)
- DEPTH, 4, number of entries; power of two, ≥2

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream packet valid
- in_ready  out  1  buffer accepts a packet this cycle
- in_pkt  in  PACKET_SIZE+32  framed packet, in the {tlp, lcrc} layout produced upstream
- in_seq  in  12  sequence number of in_pkt
- out_valid  out  1  packet presented to transmitter
- out_ready  in  1  transmitter takes packet
- out_pkt  out  PACKET_SIZE+32  packet being sent
- out_seq  out  12  its sequence number
- ack_valid  in  1  DLLP ACK/NAK received
- ack_nak  in  1  1 = NAK, 0 = ACK
- ack_seq  in  12  AckNak_Seq_Num
- ack_ready  out  1  ACK/NAK accepted this cycle
- replay_active  out  1  high while in REPLAY
- replay_rollover  out  1  one-cycle pulse when replay_num wraps 3→0
- ack_err  out  1  one-cycle pulse: ACK/NAK covered an unsent entry
- count  out  $clog2(DEPTH)+1  entries held

## Operation
**Pointers.** Three pointers, each $clog2(DEPTH)+1 bits with a wrap bit:
- rd_ptr: oldest unacknowledged entry.
- send_ptr: next entry to transmit.
- wr_ptr: next free slot.
- Invariant: rd_ptr ≤ send_ptr ≤ wr_ptr (modular).
- count = wr_ptr − rd_ptr.

**Handshakes.**
- Write occurs when in_valid && in_ready.
- in_ready = (count < DEPTH) && state != REPLAY.
- out_valid = (send_ptr != wr_ptr).
- out_pkt and out_seq are read from the entry at send_ptr.
- send_ptr increments on out_valid && out_ready.

**ACK coverage.** An entry with sequence e is covered by S iff ((S − e) mod 4096) < 2048.

**States.** Three states: IDLE, PURGE, REPLAY.
- IDLE
  - ack_ready = 1.
  - On ack_valid: latch S and nak, then go to PURGE.
- PURGE
  - Frees one entry per cycle: if rd_ptr != send_ptr and entry[rd_ptr] is covered by S, rd_ptr++.
  - Otherwise purge ends:
    - If rd_ptr == send_ptr and entry[rd_ptr] is covered and rd_ptr != wr_ptr, pulse ack_err.
    - If nak: send_ptr ← rd_ptr, go to REPLAY.
    - Else go to IDLE.
  - ack_ready = 0.
  - Writes and sends continue normally during PURGE.
- REPLAY
  - Transmits entries from send_ptr up to wr_ptr.
  - Returns to IDLE in the cycle the last entry handshakes, or immediately if send_ptr == wr_ptr.
  - in_ready = 0 and ack_ready = 0.

**replay_num** (2 bits).
- Reset to 0 when an ACK or NAK purge frees ≥1 entry.
- Otherwise incremented on entering REPLAY.
- Increment 3→0 pulses replay_rollover; the replay still proceeds.

**Boundary behaviour.**
- ACK/NAK on an empty buffer: PURGE lasts 1 cycle and frees nothing. A NAK then enters REPLAY and exits on the next cycle.
- A stale ACK (covers nothing): 1 cycle in PURGE, no change.
- Full (count == DEPTH): in_ready = 0. A purge in the same cycle raises in_ready on the next cycle.
- Simultaneous write and purge: count is unchanged.
- A write in the same cycle as a send of a different entry is permitted.
- Reset, including mid-PURGE or mid-REPLAY:
  - state IDLE; all pointers, count and replay_num 0.
  - out_valid 0, replay_active 0, replay_rollover 0, ack_err 0.
  - Storage contents are don't-care.

## Timing
- Write → out_valid: 1 cycle (entry visible the cycle after the write handshake).
- ACK accepted at cycle N: PURGE starts at N+1. k covered entries take k+1 cycles; ack_ready returns to 1 on the cycle after PURGE ends.
- NAK: the first replayed packet is valid on the cycle after PURGE ends.
- out_pkt must be held stable while out_valid && !out_ready.
- Pulse outputs are registered and last exactly 1 cycle.

## Structure
- Package dll_pkg: SEQ_W = 12, SEQ_HALF = 2048, state enum {IDLE, PURGE, REPLAY}, and a seq_covered(S, e) function.
- Sub-module replay_mem: DEPTH × (PACKET_SIZE+44) storage with synchronous write and asynchronous read. It has two read ports, one for the send pointer and one for the purge compare.
- Top level holds the FSM, the pointers and the replay counter.

## Test plan
- Write seq 0..3 with out_ready = 1 → transmitted in order; count = 4 and in_ready = 0.
- ACK seq 1 with 4 held → 2 purge cycles; count 4→2; ack_ready low for 3 cycles; in_ready back to 1.
- NAK seq 1 with seq 0..3 sent → purges 0 and 1, then replays seq 2 and 3 with identical out_pkt. replay_active is high throughout, and in_valid is held off during the replay.
- Four consecutive NAKs of seq 4095 (covers nothing) with 2 held → replay_rollover pulses on the 4th replay; the next covering ACK clears replay_num.
- ACK seq 2 while only seq 0..1 are sent and seq 2 is still unsent → purge 0 and 1, then ack_err pulses once; send_ptr is unchanged.
- Reset asserted mid-REPLAY → next cycle out_valid = 0, count = 0, in_ready = 1, replay_active = 0.
